// File: rtl/wb_ram_bytesel.sv
// Wishbone classic slave RAM with byte-lane writes, optional wait states,
// and err termination for out-of-range or misaligned accesses.
module wb_ram_bytesel #(
  parameter int unsigned DAT_WIDTH       = 64,
  parameter int unsigned ADR_WIDTH       = 32,
  parameter int unsigned WORDS           = 128,
  parameter int unsigned WAIT_STATES     = 0,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ram_cyc_i,
  input  logic                   ram_stb_i,
  input  logic                   ram_we_i,
  input  logic [ADR_WIDTH-1:0]   ram_adr_i,
  input  logic [DAT_WIDTH/8-1:0] ram_sel_i,
  input  logic [DAT_WIDTH-1:0]   ram_dat_i,
  output logic [DAT_WIDTH-1:0]   ram_dat_o,
  output logic                   ram_ack_o,
  output logic                   ram_err_o
);

  localparam int unsigned SEL_W = DAT_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(SEL_W);
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 ack_q;
  logic                 err_q;
  logic [DAT_WIDTH-1:0] dat_q;

  logic [DAT_WIDTH-1:0] mem_q [WORDS];

  logic                 req;
  logic [ADR_WIDTH-1:0] idx;
  logic [IDX_W-1:0]     widx;
  logic                 in_range;
  logic                 misalign;
  logic                 acc_err;
  logic                 respond;
  logic                 mem_we;

  // Handshake: a request is cyc & stb; the slave terminates it with exactly one
  // of ack/err, both gated by the live request, and held until the master drops stb.
  always_comb begin
    req      = ram_cyc_i & ram_stb_i;
    idx      = ram_adr_i >> OFFS;
    widx     = idx[IDX_W-1:0];
    in_range = (idx < ADR_WIDTH'(WORDS));
    misalign = (ram_adr_i[OFFS-1:0] != '0);
    acc_err  = !in_range || (ERR_ON_MISALIGN && misalign);
    respond  = 1'b0;
    if (req) begin
      if (state_q == ST_IDLE && NO_WAIT) begin
        respond = 1'b1;
      end else if (state_q == ST_WAIT && cnt_q == 4'd0) begin
        respond = 1'b1;
      end
    end
    // A reset landing on the response edge must not commit the write.
    mem_we = rst_ni && respond && !acc_err && ram_we_i;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (ram_sel_i[k]) begin
          mem_q[widx][8*k +: 8] <= ram_dat_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (NO_WAIT) begin
              state_q <= ST_RESP;
              if (acc_err) begin
                err_q <= 1'b1;
              end else begin
                ack_q <= 1'b1;
                if (!ram_we_i) begin
                  dat_q <= mem_q[widx];
                end
              end
            end else begin
              cnt_q   <= WAIT_LOAD;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            if (acc_err) begin
              err_q <= 1'b1;
            end else begin
              ack_q <= 1'b1;
              if (!ram_we_i) begin
                dat_q <= mem_q[widx];
              end
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (!req) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ram_ack_o = req & ack_q;
  assign ram_err_o = req & err_q;
  assign ram_dat_o = dat_q;

endmodule
